euler_issue_ctrl: RTL and testbench
===================================

// Module: euler_issue_ctrl
// PURPOSE
//  Sequences the read stage of the Euler pipeline (RD -> MT -> ACC -> WB). Per step,
//  issues one register-address pair per state variable i: x_i and its derivative f_i.
//  A per-variable scoreboard stalls issue of x_i until the previous step's writeback of x_i
//  retires (RAW hazard). start/done handshake with the host; counts completed steps.
// PARAMETERS
//  ADDR_W  4   register address width (matches RD/MT buffer fields)
//  N_VARS  4   state variables per step, 1..2**(ADDR_W-1)
//  F_BASE  8   address of f_0; f_i = F_BASE+i; x_i = i
//  STEP_W  16  width of step count / counter
// PORTS
//  clk       in   1       clock, rising edge
//  rst       in   1       asynchronous, active-high reset
//  start     in   1       pulse: begin run; sampled only in IDLE
//  n_steps   in   STEP_W  steps to run; sampled with start
//  stall_in  in   1       downstream RD/MT buffer cannot accept this cycle
//  wb_valid  in   1       writeback stage retiring x[wb_addr]
//  wb_addr   in   ADDR_W  index of retired x
//  rd_valid  out  1       rd_addr1/rd_addr2 valid this cycle
//  rd_addr1  out  ADDR_W  x_i address (to RD/MT buffer d1)
//  rd_addr2  out  ADDR_W  f_i address (to RD/MT buffer d2)
//  busy      out  1       high in ISSUE/DRAIN
//  done      out  1       one-cycle pulse at end of run
//  step_cnt  out  STEP_W  steps fully issued in current run
// BEHAVIOUR
//  Reset: state IDLE; rd_valid, rd_addr1, rd_addr2, busy, done, step_cnt = 0; scoreboard clear.
//  All outputs registered. FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//  IDLE: start=1 & n_steps!=0 -> ISSUE, var_idx=0, step_cnt=0; start & n_steps==0 -> DONE.
//  ISSUE: issue iff !stall_in & !sb[var_idx]. On issue (next edge): rd_valid=1,
//   rd_addr1=var_idx, rd_addr2=F_BASE+var_idx, sb[var_idx] set, var_idx++.
//   Else rd_valid=0, addresses hold. First issue at earliest one cycle after start.
//  var_idx wraps N_VARS-1 -> 0 and step_cnt++ on that issue; if step_cnt reaches n_steps
//   -> DRAIN.
//  DRAIN: rd_valid=0; when scoreboard all-clear -> DONE.
//  DONE: done=1 for exactly one cycle, busy=0, step_cnt holds final value -> IDLE.
//  Scoreboard: wb_valid clears sb[wb_addr]; clear visible next cycle (no bypass), so
//   retire and re-issue of same x_i take >= 2 cycles. Set and clear of different
//   indices in one cycle both take effect. wb_addr >= N_VARS or of clear bit: ignored.
//  start outside IDLE ignored. step_cnt, rd addresses never exceed declared widths.
//  rst mid-run: immediate return to IDLE, scoreboard cleared; late wb_valid harmless.
// STRUCTURE
//  euler_defs.vh: FSM state localparams (IDLE/ISSUE/DRAIN/DONE), ADDR_W/STEP_W defaults.
//  Sub-module euler_scoreboard: N_VARS busy bits, set/clear ports, any_busy, bit lookup.
//  Top: FSM, var_idx/step counters, registered issue outputs.
// TESTING
//  1 N_VARS=4, n_steps=1, no stall, wb 3 cycles after each issue -> addr pairs (0,8)(1,9)
//    (2,10)(3,11) on 4 consecutive cycles; done one cycle after last wb clears.
//  2 n_steps=2, wb withheld for x_0 -> second step stalls at var 0 (rd_valid=0) until
//    wb_addr=0 seen, issue of (0,8) exactly 2 cycles after that wb_valid.
//  3 stall_in held high 5 cycles mid-step -> no issue, rd_addr holds, resumes same var_idx.
//  4 start with n_steps=0 -> done pulse, busy never high, rd_valid never high.
//  5 rst asserted during ISSUE step 3 of 5 -> all outputs 0 same cycle; new start runs
//    cleanly from var 0, step_cnt 0.
//  6 start pulsed while busy -> ignored; wb_addr=12 -> no scoreboard effect.

Source files
------------

// File: rtl/euler_issue_ctrl_pkg.sv
// Shared definitions for the Euler read-stage issue controller.
// Holds the FSM state encoding and the default address and step widths.
package euler_issue_ctrl_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int STEP_W_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/euler_issue_ctrl_scoreboard.sv
// Per-variable RAW scoreboard: one busy bit per state variable x_i.
// A clear becomes visible on the cycle after it is sampled. Out-of-range clears are dropped.
module euler_scoreboard #(
    parameter int ADDR_W = 4,
    parameter int N_VARS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set,
    input  logic [ADDR_W-1:0] i_set_idx,
    input  logic              i_clr,
    input  logic [ADDR_W-1:0] i_clr_idx,
    input  logic [ADDR_W-1:0] i_lookup_idx,
    output logic              o_lookup,
    output logic              o_any_busy
);

    localparam int FULL = 2 ** ADDR_W;
    localparam logic [N_VARS-1:0] ONE = N_VARS'(1);

    logic [N_VARS-1:0] r_sb;
    logic [N_VARS-1:0] w_set_mask;
    logic [N_VARS-1:0] w_clr_mask;
    logic [FULL-1:0]   w_sb_full;

    // Shifting past N_VARS yields an empty mask, so wb_addr >= N_VARS is ignored.
    assign w_set_mask = i_set ? (ONE << i_set_idx) : '0;
    assign w_clr_mask = i_clr ? (ONE << i_clr_idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb <= '0;
        end else begin
            // NOTE: set is OR-ed in after the clear, so set wins on a same-index collision.
            r_sb <= (r_sb & ~w_clr_mask) | w_set_mask;
        end
    end

    assign w_sb_full  = {{(FULL - N_VARS){1'b0}}, r_sb};
    assign o_lookup   = w_sb_full[i_lookup_idx];
    assign o_any_busy = |r_sb;

endmodule

// File: rtl/euler_issue_ctrl.sv
// Read-stage issue controller for the Euler pipeline: issues (x_i, f_i) address pairs per step,
// stalls on downstream backpressure or an outstanding writeback of x_i, and counts issued steps.
module euler_issue_ctrl
    import euler_issue_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int N_VARS = 4,
    parameter int F_BASE = 8,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [STEP_W-1:0] n_steps,
    input  logic              stall_in,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] step_cnt
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_VARS - 1);
    localparam logic [ADDR_W-1:0] F_OFS    = ADDR_W'(F_BASE);

    state_t            r_state;
    logic [ADDR_W-1:0] r_var_idx;
    logic [STEP_W-1:0] r_n_steps;
    logic [STEP_W-1:0] r_step_cnt;
    logic              r_rd_valid;
    logic [ADDR_W-1:0] r_rd_addr1;
    logic [ADDR_W-1:0] r_rd_addr2;
    logic              r_busy;
    logic              r_done;

    logic              w_sb_hit;
    logic              w_any_busy;
    logic              w_issue;
    logic [STEP_W-1:0] w_step_next;

    assign w_issue     = (r_state == S_ISSUE) && !stall_in && !w_sb_hit;
    assign w_step_next = r_step_cnt + STEP_W'(1);

    euler_scoreboard #(
        .ADDR_W (ADDR_W),
        .N_VARS (N_VARS)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .i_set        (w_issue),
        .i_set_idx    (r_var_idx),
        .i_clr        (wb_valid),
        .i_clr_idx    (wb_addr),
        .i_lookup_idx (r_var_idx),
        .o_lookup     (w_sb_hit),
        .o_any_busy   (w_any_busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_var_idx  <= '0;
            r_n_steps  <= '0;
            r_step_cnt <= '0;
            r_rd_valid <= 1'b0;
            r_rd_addr1 <= '0;
            r_rd_addr2 <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here; each state only raises what it needs.
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n_steps  <= n_steps;
                        r_step_cnt <= '0;
                        r_var_idx  <= '0;
                        if (n_steps != '0) begin
                            r_state <= S_ISSUE;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        r_rd_valid <= 1'b1;
                        r_rd_addr1 <= r_var_idx;
                        r_rd_addr2 <= F_OFS + r_var_idx;
                        if (r_var_idx == LAST_IDX) begin
                            r_var_idx  <= '0;
                            r_step_cnt <= w_step_next;
                            if (w_step_next == r_n_steps) begin
                                r_state <= S_DRAIN;
                            end
                        end else begin
                            r_var_idx <= r_var_idx + ADDR_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!w_any_busy) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_addr1 = r_rd_addr1;
    assign rd_addr2 = r_rd_addr2;
    assign busy     = r_busy;
    assign done     = r_done;
    assign step_cnt = r_step_cnt;

endmodule

// File: tb/tb_euler_issue_ctrl.sv
// Bench for euler_issue_ctrl: directed scenarios plus randomized runs checked against
// a transaction-level model of issue order, RAW spacing, step counting and done timing.
module tb_euler_issue_ctrl;

    localparam int ADDR_W = 4;
    localparam int N_VARS = 4;
    localparam int F_BASE = 8;
    localparam int STEP_W = 16;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              start    = 1'b0;
    logic [STEP_W-1:0] n_steps  = '0;
    logic              stall_in = 1'b0;
    logic              wb_valid = 1'b0;
    logic [ADDR_W-1:0] wb_addr  = '0;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] step_cnt;

    int n_cmp       = 0;
    int n_err       = 0;
    int cyc         = 0;
    int last_wb_cyc = -100;
    int done_cyc    = -1;
    int q_addr[$];
    int q_due[$];

    euler_issue_ctrl #(
        .ADDR_W (ADDR_W),
        .N_VARS (N_VARS),
        .F_BASE (F_BASE),
        .STEP_W (STEP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n_steps  (n_steps),
        .stall_in (stall_in),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .rd_valid (rd_valid),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .busy     (busy),
        .done     (done),
        .step_cnt (step_cnt)
    );

    always #5 clk = ~clk;

    // Outputs are observed on the falling edge; inputs are driven right after observing.
    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic push_wb(input int a, input int due);
        q_addr.push_back(a);
        q_due.push_back(due);
    endtask

    task automatic service_wb(input bit junk);
        wb_valid = 1'b0;
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            wb_valid    = 1'b1;
            wb_addr     = ADDR_W'(q_addr.pop_front());
            void'(q_due.pop_front());
            last_wb_cyc = cyc;
        end else if (junk && $urandom_range(3, 0) == 0) begin
            wb_valid = 1'b1;
            wb_addr  = ADDR_W'($urandom_range(15, N_VARS));
        end
    endtask

    task automatic idle_gap();
        wb_valid = 1'b0;
        stall_in = 1'b0;
        start    = 1'b0;
        q_addr.delete();
        q_due.delete();
        repeat (2) tick();
    endtask

    task automatic do_start(input int n);
        start    = 1'b1;
        n_steps  = STEP_W'(n);
        stall_in = 1'b0;
        tick();
        start    = 1'b0;
    endtask

    task automatic run_until_done(input int max_cyc, input int delay, output bit got, output int issued);
        got    = 1'b0;
        issued = 0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (rd_valid) begin
                push_wb(int'(rd_addr1), cyc + delay);
                issued++;
            end
            if (done) begin
                got      = 1'b1;
                done_cyc = cyc;
                break;
            end
            service_wb(1'b0);
        end
        wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_cmp++; if ({rd_valid, busy, done, rd_addr1, rd_addr2, step_cnt} !== '0) begin n_err++;
            $display("FAIL reset_outputs: got %h expected 0", {rd_valid, busy, done, rd_addr1, rd_addr2, step_cnt}); end
        rst = 1'b0;
        tick();
        n_cmp++; if ({rd_valid, busy, done} !== 3'b000) begin n_err++;
            $display("FAIL reset_release_idle: got %b expected 000", {rd_valid, busy, done}); end
    endtask

    task automatic test_single_step();
        bit got; int issued;
        idle_gap();
        do_start(1);
        n_cmp++; if ({busy, rd_valid} !== 2'b10) begin n_err++;
            $display("FAIL t1_start_state: got busy,rd_valid=%b expected 10", {busy, rd_valid}); end
        for (int k = 0; k < N_VARS; k++) begin
            tick();
            n_cmp++; if (!(rd_valid === 1'b1 && rd_addr1 === ADDR_W'(k) && rd_addr2 === ADDR_W'(F_BASE + k))) begin n_err++;
                $display("FAIL t1_issue_%0d: got v=%b (%0d,%0d) expected v=1 (%0d,%0d)", k, rd_valid, rd_addr1, rd_addr2, k, F_BASE + k); end
            push_wb(k, cyc + 3);
            service_wb(1'b0);
        end
        run_until_done(60, 3, got, issued);
        n_cmp++; if (!got || done_cyc != last_wb_cyc + 2) begin n_err++;
            $display("FAIL t1_done_timing: got done=%b at %0d expected at %0d", got, done_cyc, last_wb_cyc + 2); end
        n_cmp++; if ({busy, step_cnt} !== {1'b0, STEP_W'(1)} || issued != 0) begin n_err++;
            $display("FAIL t1_final: got busy=%b step_cnt=%0d extra=%0d expected busy=0 step_cnt=1 extra=0", busy, step_cnt, issued); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_err++;
            $display("FAIL t1_done_pulse: got done=%b expected 0", done); end
    endtask

    task automatic test_raw_hazard();
        bit got; int issued; int m;
        idle_gap();
        do_start(2);
        for (int k = 0; k < N_VARS; k++) begin
            tick();
            n_cmp++; if (!(rd_valid === 1'b1 && rd_addr1 === ADDR_W'(k))) begin n_err++;
                $display("FAIL t2_step1_issue_%0d: got v=%b addr1=%0d expected v=1 addr1=%0d", k, rd_valid, rd_addr1, k); end
            if (k != 0) push_wb(k, cyc + 1);
            service_wb(1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (rd_valid !== 1'b0) begin n_err++;
                $display("FAIL t2_raw_hold_%0d: got rd_valid=%b expected 0", i, rd_valid); end
            service_wb(1'b0);
        end
        wb_valid = 1'b1;
        wb_addr  = '0;
        m        = cyc;
        tick();
        wb_valid = 1'b0;
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++;
            $display("FAIL t2_no_bypass: got rd_valid=%b at wb+1 expected 0", rd_valid); end
        tick();
        n_cmp++; if (!(cyc == m + 2 && rd_valid === 1'b1 && rd_addr1 === 4'd0 && rd_addr2 === 4'd8)) begin n_err++;
            $display("FAIL t2_reissue: got v=%b (%0d,%0d) expected v=1 (0,8)", rd_valid, rd_addr1, rd_addr2); end
        push_wb(0, cyc + 1);
        service_wb(1'b0);
        run_until_done(100, 2, got, issued);
        n_cmp++; if (!got || issued != N_VARS - 1 || step_cnt !== STEP_W'(2)) begin n_err++;
            $display("FAIL t2_final: got done=%b issued=%0d step_cnt=%0d expected done=1 issued=%0d step_cnt=2", got, issued, step_cnt, N_VARS - 1); end
        tick();
    endtask

    task automatic test_stall_in();
        bit got; int issued;
        idle_gap();
        do_start(1);
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++; if (!(rd_valid === 1'b1 && rd_addr1 === ADDR_W'(k))) begin n_err++;
                $display("FAIL t3_pre_issue_%0d: got v=%b addr1=%0d expected v=1 addr1=%0d", k, rd_valid, rd_addr1, k); end
            push_wb(k, cyc + 1);
            service_wb(1'b0);
        end
        stall_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (!(rd_valid === 1'b0 && rd_addr1 === 4'd1 && rd_addr2 === 4'd9)) begin n_err++;
                $display("FAIL t3_stall_%0d: got v=%b (%0d,%0d) expected v=0 (1,9)", i, rd_valid, rd_addr1, rd_addr2); end
            service_wb(1'b0);
        end
        stall_in = 1'b0;
        tick();
        n_cmp++; if (!(rd_valid === 1'b1 && rd_addr1 === 4'd2 && rd_addr2 === 4'd10)) begin n_err++;
            $display("FAIL t3_resume: got v=%b (%0d,%0d) expected v=1 (2,10)", rd_valid, rd_addr1, rd_addr2); end
        push_wb(2, cyc + 1);
        service_wb(1'b0);
        run_until_done(100, 1, got, issued);
        n_cmp++; if (!got || issued != 1 || step_cnt !== STEP_W'(1)) begin n_err++;
            $display("FAIL t3_final: got done=%b issued=%0d step_cnt=%0d expected 1,1,1", got, issued, step_cnt); end
        tick();
    endtask

    task automatic test_zero_steps();
        idle_gap();
        do_start(0);
        n_cmp++; if ({done, busy, rd_valid} !== 3'b100) begin n_err++;
            $display("FAIL t4_done: got done,busy,rd_valid=%b expected 100", {done, busy, rd_valid}); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if ({done, busy, rd_valid, step_cnt} !== '0) begin n_err++;
                $display("FAIL t4_quiet_%0d: got done,busy,rd_valid=%b step_cnt=%0d expected 000 0", i, {done, busy, rd_valid}, step_cnt); end
        end
    endtask

    task automatic test_reset_mid_run();
        bit got; int issued; int seen;
        idle_gap();
        do_start(5);
        seen = 0;
        for (int i = 0; i < 200 && seen < 2 * N_VARS + 1; i++) begin
            tick();
            if (rd_valid) begin
                push_wb(int'(rd_addr1), cyc + 1);
                seen++;
            end
            service_wb(1'b0);
        end
        n_cmp++; if (seen != 2 * N_VARS + 1 || step_cnt !== STEP_W'(2) || busy !== 1'b1) begin n_err++;
            $display("FAIL t5_in_step3: got issues=%0d step_cnt=%0d busy=%b expected %0d,2,1", seen, step_cnt, busy, 2 * N_VARS + 1); end
        rst      = 1'b1;
        wb_valid = 1'b1;
        wb_addr  = 4'd1;
        #1;
        n_cmp++; if ({rd_valid, busy, done, rd_addr1, rd_addr2, step_cnt} !== '0) begin n_err++;
            $display("FAIL t5_async_reset: got %h expected 0", {rd_valid, busy, done, rd_addr1, rd_addr2, step_cnt}); end
        repeat (2) tick();
        rst = 1'b0;
        q_addr.delete();
        q_due.delete();
        tick();
        wb_valid = 1'b0;
        tick();
        do_start(1);
        n_cmp++; if (busy !== 1'b1 || step_cnt !== '0) begin n_err++;
            $display("FAIL t5_restart: got busy=%b step_cnt=%0d expected 1,0", busy, step_cnt); end
        tick();
        n_cmp++; if (!(rd_valid === 1'b1 && rd_addr1 === 4'd0 && rd_addr2 === 4'd8)) begin n_err++;
            $display("FAIL t5_first_issue: got v=%b (%0d,%0d) expected v=1 (0,8)", rd_valid, rd_addr1, rd_addr2); end
        push_wb(0, cyc + 1);
        service_wb(1'b0);
        run_until_done(100, 1, got, issued);
        n_cmp++; if (!got || step_cnt !== STEP_W'(1)) begin n_err++;
            $display("FAIL t5_final: got done=%b step_cnt=%0d expected 1,1", got, step_cnt); end
        tick();
    endtask

    task automatic test_ignored_inputs();
        int m;
        idle_gap();
        do_start(1);
        for (int k = 0; k < N_VARS; k++) begin
            tick();
            n_cmp++; if (!(rd_valid === 1'b1 && rd_addr1 === ADDR_W'(k))) begin n_err++;
                $display("FAIL t6_issue_%0d: got v=%b addr1=%0d expected v=1 addr1=%0d", k, rd_valid, rd_addr1, k); end
            if (k != 0) push_wb(k, cyc + 1);
            start   = (k == 1);
            n_steps = STEP_W'(7);
            service_wb(1'b0);
        end
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if ({done, busy} !== 2'b01) begin n_err++;
                $display("FAIL t6_drain_hold_%0d: got done,busy=%b expected 01", i, {done, busy}); end
            service_wb(1'b0);
            if (!wb_valid) begin
                wb_valid = 1'b1;
                wb_addr  = 4'd12;
            end
        end
        wb_valid = 1'b1;
        wb_addr  = '0;
        m        = cyc;
        tick();
        wb_valid = 1'b0;
        n_cmp++; if (done !== 1'b0) begin n_err++;
            $display("FAIL t6_done_early: got done=%b at wb+1 expected 0", done); end
        tick();
        n_cmp++; if (!(cyc == m + 2 && done === 1'b1 && step_cnt === STEP_W'(1))) begin n_err++;
            $display("FAIL t6_done: got done=%b step_cnt=%0d expected done=1 step_cnt=1", done, step_cnt); end
        tick();
        n_cmp++; if ({done, busy, rd_valid} !== 3'b000) begin n_err++;
            $display("FAIL t6_back_idle: got done,busy,rd_valid=%b expected 000", {done, busy, rd_valid}); end
    endtask

    // Model: the k-th issue of a run must be x_(k mod N); x_i may issue only when it has no
    // outstanding writeback and its last retire was driven at least two cycles earlier.
    task automatic test_random();
        bit outst[N_VARS];
        int ret_cyc[N_VARS];
        int n, total, issues, last_ret, v;
        bit prev_stall, exp_valid, exp_done, got;
        for (int r = 0; r < 20; r++) begin
            idle_gap();
            n        = $urandom_range(4, 1);
            total    = n * N_VARS;
            issues   = 0;
            last_ret = -100;
            for (int i = 0; i < N_VARS; i++) begin
                outst[i]   = 1'b0;
                ret_cyc[i] = -100;
            end
            do_start(n);
            prev_stall = 1'b0;
            got        = 1'b0;
            n_cmp++; if ({busy, rd_valid, step_cnt} !== {2'b10, STEP_W'(0)}) begin n_err++;
                $display("FAIL rnd%0d_start: got busy=%b rd_valid=%b step_cnt=%0d expected 1,0,0", r, busy, rd_valid, step_cnt); end
            for (int i = 0; i < 400 && !got; i++) begin
                tick();
                v         = issues % N_VARS;
                exp_valid = (issues < total) && !prev_stall && !outst[v] && (cyc - ret_cyc[v] >= 2);
                n_cmp++; if (rd_valid !== exp_valid) begin n_err++;
                    $display("FAIL rnd%0d_rd_valid@%0d: got %b expected %b (var %0d)", r, cyc, rd_valid, exp_valid, v); end
                if (rd_valid && exp_valid) begin
                    n_cmp++; if (rd_addr1 !== ADDR_W'(v) || rd_addr2 !== ADDR_W'(F_BASE + v)) begin n_err++;
                        $display("FAIL rnd%0d_addr@%0d: got (%0d,%0d) expected (%0d,%0d)", r, cyc, rd_addr1, rd_addr2, v, F_BASE + v); end
                end
                if (rd_valid) begin
                    outst[v] = 1'b1;
                    push_wb(v, cyc + $urandom_range(4, 0));
                    issues++;
                end
                n_cmp++; if (step_cnt !== STEP_W'(issues / N_VARS)) begin n_err++;
                    $display("FAIL rnd%0d_step_cnt@%0d: got %0d expected %0d", r, cyc, step_cnt, issues / N_VARS); end
                exp_done = (issues == total) && (q_due.size() == 0) && (cyc == last_ret + 2);
                n_cmp++; if (done !== exp_done || busy !== !exp_done) begin n_err++;
                    $display("FAIL rnd%0d_done@%0d: got done=%b busy=%b expected done=%b busy=%b", r, cyc, done, busy, exp_done, !exp_done); end
                if (done) begin
                    got = 1'b1;
                end else begin
                    stall_in   = ($urandom_range(9, 0) < 3);
                    prev_stall = stall_in;
                    service_wb(1'b1);
                    if (wb_valid && wb_addr < ADDR_W'(N_VARS)) begin
                        outst[int'(wb_addr)]   = 1'b0;
                        ret_cyc[int'(wb_addr)] = cyc;
                        last_ret               = cyc;
                    end
                end
            end
            n_cmp++; if (!got) begin n_err++;
                $display("FAIL rnd%0d_timeout: got no done within 400 cycles expected done (issues %0d of %0d)", r, issues, total); end
            stall_in = 1'b0;
            wb_valid = 1'b0;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_raw_hazard();
        test_stall_in();
        test_zero_steps();
        test_reset_mid_run();
        test_ignored_inputs();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
